// File: rtl/nand_tv_pkg.sv
// Shared types, sizes and the reference gate function for the NAND test-vector checker.
package nand_tv_pkg;

   localparam int VEC_W   = 2;
   localparam int NUM_VEC = 4;
   localparam int ERR_W   = 3;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } tv_state_e;

   function automatic logic nand_expect(input logic a, input logic b);
      return ~(a & b);
   endfunction

endpackage

// File: rtl/nand_tv_checker_if.sv
// Stimulus/response and result bundle between the checker and the gate under test.
interface nand_tv_checker_if;
   import nand_tv_pkg::*;

   logic             start;
   logic             a;
   logic             b;
   logic             y;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [VEC_W-1:0] fail_vec;

   modport master (
      input  start, y,
      output a, b, busy, done, pass, err_cnt, fail_vec
   );

   modport slave (
      output start, y,
      input  a, b, busy, done, pass, err_cnt, fail_vec
   );

endinterface

// File: rtl/tv_settle_timer.sv
// Settle timer: down-counter reloaded when a vector is applied; sample is high on
// the SETTLE-th edge after the load, then it reloads for the next vector.
module tv_settle_timer
   import nand_tv_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic sample
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt;

   assign sample = en && (cnt == '0);

   // count down while enabled, reload on a new sweep or on each terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load || sample) begin
         cnt <= RELOAD;
      end else if (en) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/nand_tv_checker.sv
// Exhaustive 2-input NAND checker: walks {A,B} through 00..11, samples Y after
// SETTLE cycles per vector and reports mismatch count and first failing vector.
//
//   state | meaning
//   IDLE  | after reset, stimulus parked at 00, no results
//   RUN   | sweep in progress, {A,B} == vec, START ignored
//   FIN   | results of last sweep valid (DONE), START begins a new sweep
module nand_tv_checker
   import nand_tv_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   nand_tv_checker_if.master        bus
);

   tv_state_e        state;
   logic [VEC_W-1:0] vec;
   logic             run;
   logic             load;
   logic             sample;
   logic             mismatch;
   logic [ERR_W-1:0] err_nxt;

   assign run  = (state == RUN);
   assign load = !run && bus.start;

   tv_settle_timer #(.SETTLE(SETTLE)) u_settle (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .en     (run),
      .sample (sample)
   );

   // Y compared with 4-state inequality so an X/Z response counts as a mismatch
   always_comb begin
      mismatch = (bus.y !== nand_expect(bus.a, bus.b));
      err_nxt  = bus.err_cnt;
      if (mismatch && (bus.err_cnt != ERR_W'(NUM_VEC))) begin
         err_nxt = bus.err_cnt + 1'b1;
      end
   end

   // sweep sequencer with registered stimulus and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         vec          <= '0;
         bus.a        <= 1'b0;
         bus.b        <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.pass     <= 1'b0;
         bus.err_cnt  <= '0;
         bus.fail_vec <= '0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (bus.start) begin
                  state        <= RUN;
                  vec          <= '0;
                  bus.a        <= 1'b0;
                  bus.b        <= 1'b0;
                  bus.busy     <= 1'b1;
                  bus.done     <= 1'b0;
                  bus.pass     <= 1'b0;
                  bus.err_cnt  <= '0;
                  bus.fail_vec <= '0;
               end
            end
            RUN: begin
               if (sample) begin
                  bus.err_cnt <= err_nxt;
                  if (mismatch && (bus.err_cnt == '0)) begin
                     bus.fail_vec <= vec;
                  end
                  if (vec == VEC_W'(NUM_VEC - 1)) begin
                     state    <= FIN;
                     bus.a    <= 1'b0;
                     bus.b    <= 1'b0;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                     bus.pass <= (err_nxt == '0);
                  end else begin
                     vec              <= vec + 1'b1;
                     {bus.a, bus.b}   <= vec + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_tv_checker.sv
// Bench for nand_tv_checker: two instances (SETTLE=1 and SETTLE=3) share START and
// reset; a gate model with a per-vector fault mask drives Y; a sweep-level model
// predicts results into a scoreboard that a negedge monitor drains.
module tb_nand_tv_checker;
   import nand_tv_pkg::*;

   typedef struct packed {
      logic       a;
      logic       b;
      logic       busy;
      logic       done;
      logic       pass;
      logic [2:0] err;
      logic [1:0] fvec;
   } obs_t;

   typedef struct packed {
      logic [2:0] err;
      logic [1:0] fvec;
      logic       pass;
   } exp_t;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       start     = 1'b0;
   logic [3:0] flip_mask = 4'b0000;
   logic       x_en      = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   nand_tv_checker_if if0();
   nand_tv_checker_if if1();

   assign if0.start = start;
   assign if1.start = start;

   nand_tv_checker #(.SETTLE(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.master)
   );

   nand_tv_checker #(.SETTLE(3)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.master)
   );

   obs_t o [2];

   always_comb begin
      o[0] = {if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_cnt, if0.fail_vec};
      o[1] = {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.err_cnt, if1.fail_vec};
   end

   // An unknown response; if the simulator resolves X to a value it is forced
   // to 0, which still differs from the NAND of vector 01.
   logic xraw = 1'bx;
   logic xfix;
   assign xfix = (xraw === 1'b1) ? 1'b0 : xraw;

   logic y0, y1;

   always_comb begin
      y0 = ~(if0.a & if0.b) ^ flip_mask[{if0.a, if0.b}];
      if (x_en && ({if0.a, if0.b} == 2'b01)) y0 = xfix;
      y1 = ~(if1.a & if1.b) ^ flip_mask[{if1.a, if1.b}];
      if (x_en && ({if1.a, if1.b} == 2'b01)) y1 = xfix;
   end

   assign if0.y = y0;
   assign if1.y = y1;

   function automatic int set_of(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic exp_t expect_of(logic [3:0] flips);
      exp_t e;
      e.err  = 3'($countones(flips));
      e.fvec = 2'b00;
      for (int i = 3; i >= 0; i--) if (flips[i]) e.fvec = 2'(i);
      e.pass = (flips == 4'b0000);
      return e;
   endfunction

   task automatic check(string nm, int d, logic [15:0] act, logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d got=%0h want=%0h", nm, d, act, exp);
   endtask

   // sweep-level reference model
   int   edge_n = 0;
   bit   mrun  [2];
   bit   mdone [2];
   int   mst   [2];
   exp_t sbq   [2][$];

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
               mrun[d]  = 1'b0;
               mdone[d] = 1'b0;
               sbq[d].delete();
            end
         end else begin
            edge_n++;
            for (int d = 0; d < 2; d++) begin
               if (mrun[d]) begin
                  if (edge_n - mst[d] == 4 * set_of(d)) begin
                     mrun[d]  = 1'b0;
                     mdone[d] = 1'b1;
                  end
               end else if (start) begin
                  mrun[d]  = 1'b1;
                  mdone[d] = 1'b0;
                  mst[d]   = edge_n;
                  sbq[d].push_back(expect_of(flip_mask | (x_en ? 4'b0010 : 4'b0000)));
               end
            end
         end
      end
   end

   // monitor: per-cycle stimulus/status checks, scoreboard pop on DONE rising
   initial begin
      bit pd [2];
      pd[0] = 1'b0;
      pd[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            logic [1:0] eab;
            exp_t       ex;
            eab = mrun[d] ? 2'((edge_n - mst[d]) / set_of(d)) : 2'b00;
            check("ab", d, {o[d].a, o[d].b}, eab);
            check("busy", d, o[d].busy, mrun[d]);
            check("done", d, o[d].done, mdone[d]);
            if (!o[d].done) check("pass_lo", d, o[d].pass, 1'b0);
            if (o[d].done && !pd[d]) begin
               check("sb_depth", d, sbq[d].size(), 1);
               if (sbq[d].size() > 0) begin
                  ex = sbq[d].pop_front();
                  check("err_cnt", d, o[d].err, ex.err);
                  check("fail_vec", d, o[d].fvec, ex.fvec);
                  check("pass", d, o[d].pass, ex.pass);
               end
            end
            pd[d] = o[d].done;
         end
      end
   end

   task automatic start_pulse(int n);
      @(posedge clk);
      #2 start = 1'b1;
      repeat (n) @(posedge clk);
      #2 start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(posedge clk);
      do begin
         @(negedge clk);
         n++;
      end while ((o[0].busy || o[1].busy) && n < 400);
      check("idle_bound", 0, {o[0].busy, o[1].busy}, 2'b00);
   endtask

   task automatic do_reset(bit start_after);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) check("rst_out", d, o[d], '0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      if (start_after) begin
         start = 1'b1;
         @(posedge clk);
         #2 start = 1'b0;
      end
   endtask

   initial begin
      #3 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) check("rst_init", d, o[d], '0);
      repeat (2) @(posedge clk);
      // START asserted together with reset release is taken on the next edge
      #2 rst_n = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      wait_idle();

      flip_mask = 4'b1111;             // AND gate in place of NAND
      start_pulse(1);
      wait_idle();

      flip_mask = 4'b1000;             // output stuck at 1
      start_pulse(1);
      wait_idle();

      flip_mask = 4'b0000;             // START held through RUN and into FIN
      start_pulse(16);
      wait_idle();

      x_en = 1'b1;                     // unknown response on vector 01
      start_pulse(1);
      wait_idle();
      x_en = 1'b0;

      flip_mask = 4'b0110;             // reset during vector 2, then clean sweep
      start_pulse(1);
      repeat (5) @(posedge clk);
      flip_mask = 4'b0000;
      do_reset(1'b1);
      wait_idle();

      for (int it = 0; it < 25; it++) begin
         flip_mask = 4'($urandom_range(0, 15));
         x_en      = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 4)) @(posedge clk);
         start_pulse($urandom_range(1, 14));
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(0, 10)) @(posedge clk);
            do_reset($urandom_range(0, 1) == 1);
         end
         wait_idle();
      end

      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) check("sb_left", d, sbq[d].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nand_tv_checker.md
NAND_TV_CHECKER -- requirements
Module: nand_tv_checker

Interface
REQ-001 Parameter SETTLE, default 1, meaning: clock cycles each vector is held before Y is sampled; legal range 1..15.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 START  input  1  request one exhaustive sweep; level-sampled on the rising edge.
REQ-005 A  output  1  stimulus to 2-input gate under test, registered.
REQ-006 B  output  1  stimulus to 2-input gate under test, registered.
REQ-007 Y  input  1  gate-under-test output; combinational from A/B.
REQ-008 BUSY  output  1  high while a sweep is in progress.
REQ-009 DONE  output  1  high while results of the last sweep are valid.
REQ-010 PASS  output  1  high with DONE when ERR_CNT is 0.
REQ-011 ERR_CNT  output  3  number of mismatching vectors in the last sweep, 0..4.
REQ-012 FAIL_VEC  output  2  {A,B} of the first mismatching vector; 0 when ERR_CNT is 0.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIN; encoding local to the package.
REQ-014 IDLE: A=B=0, BUSY=0, DONE=0; START=1 at an edge -> RUN, vector index VEC=0, ERR_CNT and FAIL_VEC cleared, settle count cleared, all on that edge.
REQ-015 In RUN, {A,B} SHALL equal VEC from the edge the vector is applied.
REQ-016 Expected output SHALL be ~(A & B), computed from the registered A/B.
REQ-017 Y SHALL be sampled at exactly the SETTLE-th edge after the vector is applied; one vector per SETTLE cycles.
REQ-018 On a sample edge with Y != expected: ERR_CNT += 1; if ERR_CNT was 0, FAIL_VEC <= VEC.
REQ-019 In simulation, Y of X or Z SHALL count as a mismatch.
REQ-020 On a sample edge with VEC < 3: VEC += 1 and new {A,B} applied on that same edge.
REQ-021 On the sample edge with VEC == 3: -> FIN; A=B=0, BUSY=0, DONE=1.
REQ-022 DONE SHALL first assert exactly 4*SETTLE edges after the START edge.
REQ-023 ERR_CNT SHALL saturate at 4; it cannot exceed 4 by construction, and no wrap is permitted.
REQ-024 START during RUN SHALL be ignored; the sweep is not restarted or extended.
REQ-025 FIN: outputs held until START=1, which behaves exactly as in IDLE (DONE drops, new sweep).
REQ-026 PASS SHALL be 0 whenever DONE is 0.

Reset
REQ-027 RST_N low SHALL immediately force IDLE, A=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, VEC=0, settle count 0.
REQ-028 Reset mid-sweep SHALL discard all partial results; no DONE pulse follows.
REQ-029 First START is honoured on the first rising edge with RST_N high.

Structure
REQ-030 Package nand_tv_pkg SHALL hold the state enum, VEC_W=2, NUM_VEC=4, ERR_W=3, and the expected-output function.
REQ-031 The settle counter SHALL be a sub-module tv_settle_timer (load, count to SETTLE, pulse "sample").
REQ-032 No other sub-modules; the gate under test is instantiated only in the bench.

Verification
REQ-033 SETTLE=1, correct NAND, START at edge 0 -> {A,B}=00,01,10,11 on edges 0..3; DONE=1, PASS=1, ERR_CNT=0 at edge 4.
REQ-034 SETTLE=1, AND gate as DUT -> ERR_CNT=4, FAIL_VEC=00, PASS=0.
REQ-035 SETTLE=3, Y stuck at 1 -> DONE at edge 12, ERR_CNT=1, FAIL_VEC=11.
REQ-036 START held high through RUN -> exactly one sweep, DONE at edge 4; START still high in FIN restarts.
REQ-037 RST_N low during vector 2 -> all outputs 0 asynchronously; next START gives a full clean sweep.
REQ-038 Y driven X on vector 01 -> ERR_CNT=1, FAIL_VEC=01.
